// File: rtl/random_pkg.sv
// Shared definitions for the random_range source: xorshift shift triples,
// control FSM encoding and the rejection-sampling mask helper.
`timescale 1ns/1ps
package random_pkg;

  localparam int XS32_A = 13;
  localparam int XS32_B = 17;
  localparam int XS32_C = 5;

  localparam int XS16_A = 7;
  localparam int XS16_B = 9;
  localparam int XS16_C = 8;

  typedef enum logic {
    SEARCH = 1'b0,
    HOLD   = 1'b1
  } fsm_t;

  // Smallest all-ones value covering limit-1; limit==0 selects the full width.
  function automatic logic [31:0] mask_from_limit(input logic [31:0] limit, input int width);
    logic [31:0] m;
    if (limit == 32'd0) begin
      m = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    end else begin
      m = limit - 32'd1;
      m = m | (m >> 1);
      m = m | (m >> 2);
      m = m | (m >> 4);
      m = m | (m >> 8);
      m = m | (m >> 16);
    end
    return m;
  endfunction

endpackage

// File: rtl/xorshift_step.sv
// Combinational xorshift next-state function for 16- or 32-bit generators.
`timescale 1ns/1ps
module xorshift_step
  import random_pkg::*;
#(
  parameter int STATE_W = 32
) (
  input  logic [STATE_W-1:0] x,
  output logic [STATE_W-1:0] y
);

  localparam int SA = (STATE_W == 16) ? XS16_A : XS32_A;
  localparam int SB = (STATE_W == 16) ? XS16_B : XS32_B;
  localparam int SC = (STATE_W == 16) ? XS16_C : XS32_C;

  logic [STATE_W-1:0] t0;
  logic [STATE_W-1:0] t1;

  assign t0 = x ^ (x << SA);
  assign t1 = t0 ^ (t0 >> SB);
  assign y  = t1 ^ (t1 << SC);

endmodule

// File: rtl/random_range.sv
// Bounded-range random draws by rejection sampling over an xorshift state.
// Define RANDOM_RANGE_STATS_EN to add the saturating 'rejects' counter port.
`timescale 1ns/1ps
module random_range
  import random_pkg::*;
#(
  parameter int                 STATE_W      = 32,
  parameter int                 OUT_W        = 8,
  parameter logic [STATE_W-1:0] SEED_DEFAULT = STATE_W'(1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seed_load,
  input  logic [STATE_W-1:0] seed,
  input  logic [OUT_W-1:0]   limit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_value
`ifdef RANDOM_RANGE_STATS_EN
  ,
  output logic [15:0]        rejects
`endif
);

  if (STATE_W != 16 && STATE_W != 32) begin : g_bad_state_w
    $error("random_range: STATE_W must be 16 or 32");
  end
  if (OUT_W < 1 || OUT_W > STATE_W) begin : g_bad_out_w
    $error("random_range: OUT_W must be in 1..STATE_W");
  end

  // A zero state would lock the generator, so a zero default becomes 1.
  localparam logic [STATE_W-1:0] SEED_INIT =
    (SEED_DEFAULT == '0) ? STATE_W'(1) : SEED_DEFAULT;

  fsm_t               fsm_reg, fsm_next;
  logic [STATE_W-1:0] state_reg, state_next;
  logic [STATE_W-1:0] step_out;
  logic               valid_reg, valid_next;
  logic [OUT_W-1:0]   value_reg, value_next;
  logic [OUT_W-1:0]   mask;
  logic [OUT_W-1:0]   cand;
  logic               accept;

  xorshift_step #(.STATE_W(STATE_W)) u_step (
    .x (state_reg),
    .y (step_out)
  );

  assign mask   = OUT_W'(mask_from_limit(32'(limit), OUT_W));
  assign cand   = state_reg[OUT_W-1:0] & mask;
  assign accept = (limit == '0) || (cand < limit);

`ifdef RANDOM_RANGE_STATS_EN
  logic [15:0] rejects_reg, rejects_next;
  assign rejects = rejects_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_reg   <= SEARCH;
      state_reg <= SEED_INIT;
      valid_reg <= 1'b0;
      value_reg <= '0;
`ifdef RANDOM_RANGE_STATS_EN
      rejects_reg <= '0;
`endif
    end else begin
      fsm_reg   <= fsm_next;
      state_reg <= state_next;
      valid_reg <= valid_next;
      value_reg <= value_next;
`ifdef RANDOM_RANGE_STATS_EN
      rejects_reg <= rejects_next;
`endif
    end
  end

  always_comb begin
    fsm_next   = fsm_reg;
    state_next = state_reg;
    valid_next = valid_reg;
    value_next = value_reg;
`ifdef RANDOM_RANGE_STATS_EN
    rejects_next = rejects_reg;
`endif
    if (seed_load) begin
      state_next = (seed != '0) ? seed : STATE_W'(1);
      valid_next = 1'b0;
      fsm_next   = SEARCH;
`ifdef RANDOM_RANGE_STATS_EN
      rejects_next = '0;
`endif
    end else begin
      case (fsm_reg)
        SEARCH: begin
          state_next = step_out;
          if (accept) begin
            value_next = cand;
            valid_next = 1'b1;
            fsm_next   = HOLD;
          end
`ifdef RANDOM_RANGE_STATS_EN
          else if (rejects_reg != 16'hFFFF) begin
            rejects_next = rejects_reg + 16'd1;
          end
`endif
        end
        HOLD: begin
          // out_value deliberately keeps the stale draw after the handshake.
          if (valid_reg && out_ready) begin
            valid_next = 1'b0;
            fsm_next   = SEARCH;
          end
        end
        default: fsm_next = SEARCH;
      endcase
    end
  end

  assign out_valid = valid_reg;
  assign out_value = value_reg;

endmodule

// File: tb/tb_random_range.sv
// Self-checking bench for random_range (STATE_W=32, OUT_W=8) against a
// draw-level reference model of the xorshift rejection sampler.
`timescale 1ns/1ps
module tb_random_range;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        seed_load = 1'b0;
  logic [31:0] seed = '0;
  logic [7:0]  limit = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_value;
`ifdef RANDOM_RANGE_STATS_EN
  logic [15:0] rejects;
`endif

  int tests = 0;
  int fails = 0;
  bit [31:0] model_x;
  int        model_rej;

  random_range dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .limit     (limit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value)
`ifdef RANDOM_RANGE_STATS_EN
    ,
    .rejects   (rejects)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit [31:0] xs32(input bit [31:0] x);
    x = x ^ (x << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

  // Next accepted draw for a given limit; k is the number of candidates consumed.
  task automatic model_draw(input int lim, output bit [7:0] v, output int k);
    int m;
    bit [7:0] c;
    bit done;
    m = 0;
    if (lim == 0) m = 255;
    else while (m < lim - 1) m = m * 2 + 1;
    k = 0;
    v = 0;
    done = 0;
    while (!done) begin
      c = model_x[7:0] & m[7:0];
      model_x = xs32(model_x);
      k++;
      if (lim == 0 || int'(c) < lim) begin
        v = c;
        done = 1;
      end else begin
        model_rej++;
      end
    end
  endtask

  task automatic load_seed(input bit [31:0] s);
    @(negedge clk);
    seed = s;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    model_x = (s == 0) ? 32'd1 : s;
    model_rej = 0;
  endtask

  task automatic get_draw(output bit [7:0] v, output int cycles, output bit ok);
    out_ready = 1'b1;
    ok = 0;
    cycles = 0;
    v = 0;
    while (!ok && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (out_valid === 1'b1) begin
        ok = 1;
        v = out_value;
      end
    end
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    ok = 0;
    n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      n++;
      if (out_valid === 1'b1) ok = 1;
    end
  endtask

  task automatic test_reset();
    bit [7:0] v;
    int c;
    bit ok;
    limit = 8'd0;
    #2 rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_value !== 8'h00) begin
      fails++;
      $display("FAIL reset_async valid=%b value=%h required valid=0 value=00", out_valid, out_value);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || out_value !== 8'h00) begin
      fails++;
      $display("FAIL reset_held valid=%b value=%h required valid=0 value=00", out_valid, out_value);
    end
    rst = 1'b0;
    model_x = 32'd1;
    get_draw(v, c, ok);
    tests++;
    if (!ok || v !== 8'h01 || c != 1) begin
      fails++;
      $display("FAIL reset_first_draw ok=%0d value=%h cycles=%0d required value=01 cycles=1", ok, v, c);
    end
    $display("[TB] reset: first draw %h after %0d cycles", v, c);
  endtask

  task automatic test_seed_one();
    bit [7:0] v;
    int c;
    bit ok;
    limit = 8'd0;
    load_seed(32'h0000_0001);
    get_draw(v, c, ok);
    tests++;
    if (!ok || v !== 8'h01 || c != 1) begin
      fails++;
      $display("FAIL seed1_draw0 value=%h cycles=%0d required value=01 cycles=1", v, c);
    end
    tests++;
    if (dut.state_reg !== 32'h0004_2021) begin
      fails++;
      $display("FAIL seed1_state state=%h required 00042021", dut.state_reg);
    end
    get_draw(v, c, ok);
    tests++;
    if (!ok || v !== 8'h21 || c != 2) begin
      fails++;
      $display("FAIL seed1_draw1 value=%h cycles=%0d required value=21 cycles=2", v, c);
    end
    $display("[TB] seed1: second draw %h", v);
  endtask

  task automatic test_seed_zero();
    bit [7:0] v;
    int c;
    bit ok;
    limit = 8'd0;
    load_seed(32'h0);
    get_draw(v, c, ok);
    tests++;
    if (!ok || v !== 8'h01 || c != 1) begin
      fails++;
      $display("FAIL seed0_draw value=%h cycles=%0d required value=01 cycles=1", v, c);
    end
    $display("[TB] seed0: draw %h", v);
  endtask

  task automatic test_limit_one();
    bit [7:0] v;
    int c;
    bit ok;
    int bad;
    bad = 0;
    limit = 8'd1;
    load_seed($urandom);
    for (int i = 0; i < 100; i++) begin
      get_draw(v, c, ok);
      tests++;
      if (!ok || v !== 8'h00 || c != ((i == 0) ? 1 : 2)) begin
        fails++;
        bad++;
        $display("FAIL limit1_draw%0d value=%h cycles=%0d required value=00 cycles=%0d",
                 i, v, c, (i == 0) ? 1 : 2);
      end
    end
    $display("[TB] limit1: 100 draws, %0d bad", bad);
  endtask

  task automatic test_limit_ten();
    bit [7:0] v, ev;
    int c, ek;
    bit ok;
    limit = 8'd10;
    load_seed(32'h0000_000F);
    for (int i = 0; i < 20; i++) begin
      model_draw(10, ev, ek);
      get_draw(v, c, ok);
      if (i == 0) begin
        tests++;
        if (c == 1) begin
          fails++;
          $display("FAIL limit10_first_reject cycles=%0d required >1", c);
        end
      end
      tests++;
      if (!ok || v !== ev || v >= 8'd10 || c != ((i == 0) ? ek : ek + 1)) begin
        fails++;
        $display("FAIL limit10_draw%0d value=%h cycles=%0d required value=%h cycles=%0d",
                 i, v, c, ev, (i == 0) ? ek : ek + 1);
      end
    end
`ifdef RANDOM_RANGE_STATS_EN
    tests++;
    if (rejects < 16'd1 || int'(rejects) != model_rej) begin
      fails++;
      $display("FAIL limit10_rejects rejects=%0d required %0d", rejects, model_rej);
    end
`endif
    $display("[TB] limit10: 20 draws, model rejects %0d", model_rej);
  endtask

  task automatic test_random();
    bit [7:0] v, ev;
    int c, ek, lim;
    bit ok;
    bit [31:0] s;
    for (int i = 0; i < 25; i++) begin
      s = $urandom;
      lim = $urandom_range(0, 255);
      limit = 8'(lim);
      load_seed(s);
      for (int j = 0; j < 4; j++) begin
        model_draw(lim, ev, ek);
        get_draw(v, c, ok);
        tests++;
        if (!ok || v !== ev || c != ((j == 0) ? ek : ek + 1)) begin
          fails++;
          $display("FAIL random_s%h_l%0d_d%0d value=%h cycles=%0d required value=%h cycles=%0d",
                   s, lim, j, v, c, ev, (j == 0) ? ek : ek + 1);
        end
      end
      $display("[TB] random: seed %h limit %0d last draw %h", s, lim, v);
    end
  endtask

  task automatic test_backpressure();
    bit [7:0] v, ev;
    int c, ek;
    bit ok;
    out_ready = 1'b0;
    limit = 8'd0;
    load_seed($urandom);
    model_draw(0, ev, ek);
    wait_valid(ok);
    tests++;
    if (!ok || out_value !== ev) begin
      fails++;
      $display("FAIL bp_first value=%h required %h", out_value, ev);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_value !== ev) begin
        fails++;
        $display("FAIL bp_hold%0d valid=%b value=%h required valid=1 value=%h", i, out_valid, out_value, ev);
      end
      limit = 8'($urandom);
    end
    limit = 8'd0;
    model_draw(0, ev, ek);
    get_draw(v, c, ok);
    tests++;
    if (!ok || v !== ev || c != ek + 1) begin
      fails++;
      $display("FAIL bp_release value=%h cycles=%0d required value=%h cycles=%0d", v, c, ev, ek + 1);
    end
    $display("[TB] backpressure: held 20 cycles, next draw %h", v);
  endtask

  task automatic test_seed_during_handshake();
    bit [7:0] v, ev;
    int c, ek;
    bit ok;
    bit [31:0] s2;
    out_ready = 1'b0;
    limit = 8'd0;
    load_seed($urandom);
    wait_valid(ok);
    s2 = $urandom;
    seed = s2;
    seed_load = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    model_x = (s2 == 0) ? 32'd1 : s2;
    model_rej = 0;
    tests++;
    if (!ok || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL hs_seed_drop valid=%b required 0", out_valid);
    end
    for (int j = 0; j < 3; j++) begin
      model_draw(0, ev, ek);
      get_draw(v, c, ok);
      tests++;
      if (!ok || v !== ev || c != ((j == 0) ? ek : ek + 1)) begin
        fails++;
        $display("FAIL hs_seed_draw%0d value=%h cycles=%0d required value=%h cycles=%0d",
                 j, v, c, ev, (j == 0) ? ek : ek + 1);
      end
    end
    $display("[TB] seed during handshake: new seed %h", s2);
  endtask

  task automatic test_async_reset();
    bit [7:0] v, ev;
    int c, ek;
    bit ok;
    out_ready = 1'b0;
    limit = 8'd0;
    load_seed(($urandom << 8) | 32'h0000_00A5);
    model_draw(0, ev, ek);
    wait_valid(ok);
    tests++;
    if (!ok || out_value !== ev) begin
      fails++;
      $display("FAIL arst_hold value=%h required %h", out_value, ev);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_value !== 8'h00) begin
      fails++;
      $display("FAIL arst_immediate valid=%b value=%h required valid=0 value=00", out_valid, out_value);
    end
`ifdef RANDOM_RANGE_STATS_EN
    tests++;
    if (rejects !== 16'd0) begin
      fails++;
      $display("FAIL arst_rejects rejects=%0d required 0", rejects);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    get_draw(v, c, ok);
    tests++;
    if (!ok || v !== 8'h01 || c != 1) begin
      fails++;
      $display("FAIL arst_first_draw value=%h cycles=%0d required value=01 cycles=1", v, c);
    end
    $display("[TB] async reset mid-hold: first draw after release %h", v);
  endtask

  initial begin
    test_reset();
    test_seed_one();
    test_seed_zero();
    test_limit_one();
    test_limit_ten();
    test_random();
    test_backpressure();
    test_seed_during_handshake();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
